// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package dm_arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned CNT_W_DEF        = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating starvation counter; at_limit flags that the waiting master must be forced in.
// Latency: count updates on the rising edge, at_limit is a decode of the current count.
// Backpressure: none; clr has priority over inc, count holds at LIMIT.
//
// Ports: clk, reset (sync, active-high), inc, clr, at_limit.
module dm_arb_starve_cnt #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt;

    assign at_limit = (cnt == LIMIT_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and one external master.
// Latency: DM request path and cpu_rdata are combinational; ext_rdata/ext_rvalid arrive one cycle after an ext read grant.
// Backpressure: ext_req waits while the CPU is using DM; after STARVE_LIMIT denied cycles ext is forced in and cpu_stall freezes the pipeline for that cycle.
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   cpu_req/we/addr/wd, cpu_rdata      MEM-stage access, combinational load data
//   cpu_stall                          hold IF..MEM this cycle
//   ext_req/we/addr/wd, ext_gnt        external request, held until granted
//   ext_rvalid, ext_rdata              registered read return for ext
//   dm_re/we/addr/wd, dm_rdata         data memory interface
//   stat_stalls, stat_ext_grants       saturating event counters (only with DM_ARB_STAT_EN)
import dm_arb_pkg::*;

module dm_arbiter #(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wd,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        dm_re,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
`ifdef DM_ARB_STAT_EN
    output logic [31:0] stat_stalls,
    output logic [31:0] stat_ext_grants,
`endif
    input  logic [31:0] dm_rdata
);

    owner_t owner;
    logic   force_ext;

    // Counter clears whenever ext is granted or stops asking, so a forced
    // grant can never repeat on consecutive cycles.
    dm_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (ext_req & ~ext_gnt),
        .clr      (ext_gnt | ~ext_req),
        .at_limit (force_ext)
    );

    always_comb begin
        owner = OWN_NONE;
        if (force_ext && ext_req) begin
            owner = OWN_EXT;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (ext_req) begin
            owner = OWN_EXT;
        end
    end

    // Only the owner reaches DM; a stalled CPU store is simply not presented.
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = '0;
        dm_wd   = '0;
        case (owner)
            OWN_CPU: begin
                dm_we   = cpu_we;
                dm_addr = cpu_addr;
                dm_wd   = cpu_wd;
            end
            OWN_EXT: begin
                dm_we   = ext_we;
                dm_addr = ext_addr;
                dm_wd   = ext_wd;
            end
            default: begin
            end
        endcase
    end

    assign dm_re     = (owner != OWN_NONE) && !dm_we;
    assign ext_gnt   = (owner == OWN_EXT);
    assign cpu_stall = force_ext & ext_req & cpu_req;
    assign cpu_rdata = (owner == OWN_CPU) ? dm_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= dm_rdata;
            end
        end
    end

`ifdef DM_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stalls     <= '0;
            stat_ext_grants <= '0;
        end else begin
            if (cpu_stall && (stat_stalls != 32'hFFFF_FFFF)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
            if (ext_gnt && (stat_ext_grants != 32'hFFFF_FFFF)) begin
                stat_ext_grants <= stat_ext_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural data memory and a read-return scoreboard.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpressure: ext requests are held by the bench until the cycle it expects them granted.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wd;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        dm_re, dm_we;
    logic [31:0] dm_addr, dm_wd, dm_rdata;
`ifdef DM_ARB_STAT_EN
    logic [31:0] stat_stalls, stat_ext_grants;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wd     (ext_wd),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .dm_re      (dm_re),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wd      (dm_wd),
`ifdef DM_ARB_STAT_EN
        .stat_stalls     (stat_stalls),
        .stat_ext_grants (stat_ext_grants),
`endif
        .dm_rdata   (dm_rdata)
    );

    // Behavioural DM: 64 words, combinational read, write on the rising edge.
    logic [31:0] mem [0:63];
    logic        mem_init;
    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'hDEAD_BEEF;   // 0x10
            mem[12] <= 32'h1111_1111;   // 0x30
        end else if (dm_we) begin
            mem[dm_addr[7:2]] <= dm_wd;
        end
    end

    // Read-return monitor: every ext_rvalid must match the head of the scoreboard
    // in exactly the cycle the bench predicted, and no other cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            tests++;
            e = exp_q.pop_front();
            if (ext_rvalid !== 1'b1 || ext_rdata !== e.d) begin
                fails++;
                $display("FAIL ext_rvalid_data cyc=%0d: got rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                         cyc, ext_rvalid, ext_rdata, e.d);
            end
        end else if (ext_rvalid === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ext_rvalid_spurious cyc=%0d: got rvalid=1 rdata=%h, want rvalid=0", cyc, ext_rdata);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic ereq, input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewd);
        cpu_req  = creq;
        cpu_we   = cwe;
        cpu_addr = caddr;
        cpu_wd   = cwd;
        ext_req  = ereq;
        ext_we   = ewe;
        ext_addr = eaddr;
        ext_wd   = ewd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: got rvalid=%b rdata=%h, want 0/0", ext_rvalid, ext_rdata);
        end
        tests++;
        if ({ext_gnt, cpu_stall, dm_re, dm_we} !== 4'b0 || dm_addr !== 32'h0 || dm_wd !== 32'h0) begin
            fails++;
            $display("FAIL reset_idle: got gnt=%b stall=%b re=%b we=%b addr=%h wd=%h, want all 0",
                     ext_gnt, cpu_stall, dm_re, dm_we, dm_addr, dm_wd);
        end
    endtask

    task automatic test_cpu_only();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (cpu_rdata !== 32'hDEAD_BEEF || cpu_stall !== 1'b0 || ext_gnt !== 1'b0) begin
            fails++;
            $display("FAIL cpu_load: got rdata=%h stall=%b gnt=%b, want deadbeef/0/0", cpu_rdata, cpu_stall, ext_gnt);
        end
        tests++;
        if (dm_re !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h10) begin
            fails++;
            $display("FAIL cpu_load_dm: got re=%b we=%b addr=%h, want 1/0/00000010", dm_re, dm_we, dm_addr);
        end
        next();
        drive(1, 1, 32'h14, 32'hA5A5_A5A5, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (dm_we !== 1'b1 || dm_re !== 1'b0 || dm_wd !== 32'hA5A5_A5A5 || dm_addr !== 32'h14) begin
            fails++;
            $display("FAIL cpu_store_dm: got we=%b re=%b addr=%h wd=%h, want 1/0/00000014/a5a5a5a5",
                     dm_we, dm_re, dm_addr, dm_wd);
        end
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (mem[5] !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL cpu_store_mem: got %h want a5a5a5a5", mem[5]);
        end
        tests++;
        if (dm_re !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'h0) begin
            fails++;
            $display("FAIL idle_dm: got re=%b we=%b addr=%h, want 0/0/0", dm_re, dm_we, dm_addr);
        end
        next();
    endtask

    task automatic test_ext_only();
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1 || dm_we !== 1'b1 || dm_re !== 1'b0 || dm_addr !== 32'h20) begin
            fails++;
            $display("FAIL ext_write: got gnt=%b we=%b re=%b addr=%h, want 1/1/0/00000020", ext_gnt, dm_we, dm_re, dm_addr);
        end
        next();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1 || dm_re !== 1'b1 || dm_we !== 1'b0) begin
            fails++;
            $display("FAIL ext_read: got gnt=%b re=%b we=%b, want 1/1/0", ext_gnt, dm_re, dm_we);
        end
        exp_q.push_back('{cyc + 1, 32'h1234_5678});
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        next();
    endtask

    task automatic test_contention();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || dm_addr !== 32'h10) begin
                fails++;
                $display("FAIL contend_deny[%0d]: got gnt=%b stall=%b addr=%h, want 0/0/00000010",
                         i, ext_gnt, cpu_stall, dm_addr);
            end
            next();
        end
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || dm_addr !== 32'h20 || dm_re !== 1'b1) begin
            fails++;
            $display("FAIL contend_force: got gnt=%b stall=%b addr=%h re=%b, want 1/1/00000020/1",
                     ext_gnt, cpu_stall, dm_addr, dm_re);
        end
        exp_q.push_back('{cyc + 1, 32'h1234_5678});
        next();
        // ext raises a fresh request: counter restarted, so the CPU wins again
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL contend_after: got gnt=%b stall=%b rdata=%h, want 0/0/deadbeef", ext_gnt, cpu_stall, cpu_rdata);
        end
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next();
    endtask

    task automatic test_stalled_store();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
        for (int i = 0; i < 4; i++) next();
        drive(1, 1, 32'h30, 32'hCAFE_F00D, 1, 0, 32'h10, 0);
        @(negedge clk);
        tests++;
        if (cpu_stall !== 1'b1 || ext_gnt !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h10) begin
            fails++;
            $display("FAIL stall_store_force: got stall=%b gnt=%b we=%b addr=%h, want 1/1/0/00000010",
                     cpu_stall, ext_gnt, dm_we, dm_addr);
        end
        exp_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        next();
        drive(1, 1, 32'h30, 32'hCAFE_F00D, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (mem[12] !== 32'h1111_1111) begin
            fails++;
            $display("FAIL stall_store_blocked: got %h want 11111111", mem[12]);
        end
        tests++;
        if (cpu_stall !== 1'b0 || dm_we !== 1'b1 || dm_addr !== 32'h30 || dm_wd !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL stall_store_retry: got stall=%b we=%b addr=%h wd=%h, want 0/1/00000030/cafef00d",
                     cpu_stall, dm_we, dm_addr, dm_wd);
        end
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (mem[12] !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL stall_store_mem: got %h want cafef00d", mem[12]);
        end
        next();
    endtask

    task automatic test_reset_mid();
        // Read granted in the same cycle reset is held: its return must be dropped.
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_gnt: got %b want 1", ext_gnt);
        end
        next();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_rd: got rvalid=%b rdata=%h, want 0/0", ext_rvalid, ext_rdata);
        end
        next();
        // Three denied cycles, then reset with the request still pending.
        drive(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
        for (int i = 0; i < 3; i++) next();
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_cnt3: got gnt=%b want 0", ext_gnt);
        end
        next();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_recount[%0d]: got gnt=%b stall=%b, want 0/0", i, ext_gnt, cpu_stall);
            end
            next();
        end
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_force: got gnt=%b stall=%b, want 1/1", ext_gnt, cpu_stall);
        end
        exp_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next();
    endtask

    task automatic test_drop();
        drive(1, 0, 32'h10, 0, 1, 1, 32'h24, 32'h5A5A_5A5A);
        for (int i = 0; i < 2; i++) next();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'h10) begin
            fails++;
            $display("FAIL drop_no_access: got gnt=%b we=%b addr=%h, want 0/0/00000010", ext_gnt, dm_we, dm_addr);
        end
        next();
        drive(1, 0, 32'h10, 0, 1, 1, 32'h24, 32'h5A5A_5A5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ext_gnt !== 1'b0) begin
                fails++;
                $display("FAIL drop_recount[%0d]: got gnt=%b want 0", i, ext_gnt);
            end
            next();
        end
        @(negedge clk);
        tests++;
        if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || dm_we !== 1'b1) begin
            fails++;
            $display("FAIL drop_force: got gnt=%b stall=%b we=%b, want 1/1/1", ext_gnt, cpu_stall, dm_we);
        end
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (mem[9] !== 32'h5A5A_5A5A) begin
            fails++;
            $display("FAIL drop_ext_write: got %h want 5a5a5a5a", mem[9]);
        end
        next();
        next();
    endtask

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next();
        next();
        test_reset();
        mem_init = 1'b0;
        reset    = 1'b0;
        next();
        test_cpu_only();
        test_ext_only();
        test_contention();
        test_stalled_store();
        test_reset_mid();
        test_drop();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d outstanding reads, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage and one external master (debug loader / DMA).
- One access is issued per cycle.
- CPU has priority. A starvation counter forces one external grant after STARVE_LIMIT denied cycles, stalling the pipeline for that cycle.
- Sits between the MEM stage and the DM instance; the DM write-data forwarding mux stays upstream on the CPU side.

Parameters:
- STARVE_LIMIT, 4: consecutive denied ext_req cycles before ext is forced; legal range 1..15.
- CNT_W, 4: starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MEM stage access this cycle (DM_RE | DM_WE)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address from ALU result
- cpu_wd  in  32  store data, already forwarded
- cpu_rdata  out  32  load data, combinational from dm_rdata
- cpu_stall  out  1  MEM stage must hold; freeze IF..MEM
- ext_req  in  1  external request; held until ext_gnt
- ext_we  in  1  external write enable
- ext_addr  in  32  external address
- ext_wd  in  32  external write data
- ext_gnt  out  1  external access issued this cycle
- ext_rvalid  out  1  one-cycle pulse: ext_rdata valid
- ext_rdata  out  32  registered external read data
- dm_re  out  1  to DM read enable
- dm_we  out  1  to DM write enable (DM writes at clock edge)
- dm_addr  out  32  to DM address
- dm_wd  out  32  to DM write data
- dm_rdata  in  32  from DM, combinational read

Behaviour:
- Reset values: starve_cnt=0, ext_rvalid=0, ext_rdata=0. All combinational outputs follow the inputs (zero when no request).
- force_ext = (starve_cnt == STARVE_LIMIT).
- Grant, evaluated combinationally each cycle:
  - force_ext & ext_req -> ext owns DM; cpu_stall = cpu_req.
  - else cpu_req -> CPU owns DM; ext_gnt = 0.
  - else ext_req -> ext owns DM.
  - else idle: dm_re = dm_we = 0; addr/wd driven 0.
- Owner drives dm_addr/dm_wd/dm_we; dm_re = owner & ~we. The non-owner never reaches DM; a stalled CPU store is not written.
- starve_cnt, next state:
  - ext_gnt | ~ext_req -> 0.
  - else if ext_req & ~ext_gnt -> +1, saturating at STARVE_LIMIT.
- ext read: ext_gnt & ~ext_we captures dm_rdata into ext_rdata; ext_rvalid=1 the next cycle for exactly one cycle. ext write gives no rvalid.
- cpu_stall is asserted only in a forced cycle. The CPU is never stalled two cycles in a row, because starve_cnt clears on grant.
- ext_req dropped before grant: counter clears; no access occurs.
- Addresses pass through unaltered; alignment checks belong to DM.
- Reset mid-operation: counter and rvalid clear the same edge; a pending ext request restarts counting after reset deasserts.
- Simultaneous cpu_req & ext_req with counter below limit: CPU wins, counter increments.

Optional Feature:
- DM_ARB_STAT_EN defined: adds outputs stat_stalls[31:0] (count of cycles with cpu_stall=1) and stat_ext_grants[31:0] (count of ext_gnt cycles). Both are saturating at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Package dm_arb_pkg: owner enum {OWN_NONE, OWN_CPU, OWN_EXT}, default STARVE_LIMIT, CNT_W.
- One sub-module, dm_arb_starve_cnt: saturating counter with inputs inc/clr, output at_limit.

Test Plan:
1. CPU only: cpu_req=1 load, addr 0x10, DM holds 0xDEADBEEF -> cpu_rdata=0xDEADBEEF same cycle; cpu_stall=0; ext_gnt=0.
2. Ext only: ext write 0x20 <= 0x12345678, then ext read 0x20 -> ext_gnt both cycles; ext_rvalid one cycle after read with ext_rdata=0x12345678.
3. Contention, STARVE_LIMIT=4: cpu_req and ext_req held high -> ext_gnt=0 for cycles 0..3; cycle 4 ext_gnt=1 and cpu_stall=1; cycle 5 CPU granted, counter 0.
4. Stalled CPU store to 0x30 during forced cycle -> DM location 0x30 unchanged that cycle; written on the following cycle when CPU regains grant.
5. Reset asserted with starve_cnt=3 and ext_rvalid pending -> next cycle starve_cnt=0, ext_rvalid=0, ext_rdata=0.
6. ext_req dropped after 2 denied cycles, then re-raised -> counter restarts from 0; forced grant needs 4 more denied cycles.
